// File: rtl/trng_pkg.sv
// Shared TRNG definitions: controller state encoding (also used for the
// wrapper status pins) and entropy source indices.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } trng_state_e;

  localparam logic [1:0] SRC_0 = 2'd0;
  localparam logic [1:0] SRC_1 = 2'd1;
  localparam logic [1:0] SRC_2 = 2'd2;
  localparam logic [1:0] SRC_3 = 2'd3;

endpackage

// File: rtl/trng_health_test.sv
// Online health tests: repetition count and adaptive proportion.
// Ports: clk, rst, data_bit, valid, clear, enable in; trip out.
module trng_health_test #(
  parameter int RCT_CUTOFF = 8,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 48,
  parameter int RUN_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic data_bit,
  input  logic valid,
  input  logic clear,
  input  logic enable,
  output logic trip
);

  localparam int APT_W = $clog2(APT_WINDOW + 1);

  logic             prev_bit;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;
  logic [APT_W-1:0] win_cnt;
  logic [APT_W-1:0] win_nxt;
  logic [APT_W-1:0] ones_cnt;
  logic [APT_W-1:0] ones_nxt;
  logic             win_end;
  logic             rct_trip;
  logic             apt_trip;
  logic             active;

  assign active = valid & enable & ~clear;

  // Next counter values if the current bit is consumed.
  // run_cnt==0 marks "no previous bit" after a clear.
  always_comb begin
    run_nxt  = run_cnt;
    win_nxt  = win_cnt;
    ones_nxt = ones_cnt;
    if (run_cnt == '0 || data_bit != prev_bit)
      run_nxt = RUN_W'(1);
    else if (run_cnt != '1)
      run_nxt = run_cnt + 1'b1;
    if (win_cnt != '1)
      win_nxt = win_cnt + 1'b1;
    if (data_bit && ones_cnt != '1)
      ones_nxt = ones_cnt + 1'b1;
  end

  assign win_end  = (win_nxt == APT_W'(APT_WINDOW));
  assign rct_trip = (run_nxt == RUN_W'(RCT_CUTOFF));
  assign apt_trip = win_end &&
    (ones_nxt >= APT_W'(APT_CUTOFF) ||
     ones_nxt <= APT_W'(APT_WINDOW - APT_CUTOFF));

  // Combinational so the controller can suppress the trip bit itself.
  assign trip = active & (rct_trip | apt_trip);

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      prev_bit <= 1'b0;
      run_cnt  <= '0;
      win_cnt  <= '0;
      ones_cnt <= '0;
    end else if (valid) begin
      prev_bit <= data_bit;
      run_cnt  <= run_nxt;
      if (win_end) begin
        win_cnt  <= '0;
        ones_cnt <= '0;
      end else begin
        win_cnt  <= win_nxt;
        ones_cnt <= ones_nxt;
      end
    end
  end

endmodule

// File: rtl/trng_source_ctrl.sv
// TRNG source sequencer: mux select, flush/settle on switch, health FSM.
// Ports: clk, rst, en, src_sel, bist_en, req, raw_bits/raw_valid in;
// mux_sel, flush, bit_out, bit_valid, health_fail, state out.
module trng_source_ctrl
  import trng_pkg::*;
#(
  parameter int SETTLE_BITS = 16,
  parameter int RCT_CUTOFF  = 8,
  parameter int APT_WINDOW  = 64,
  parameter int APT_CUTOFF  = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] src_sel,
  input  logic       bist_en,
  input  logic       req,
  input  logic [3:0] raw_bits,
  input  logic [3:0] raw_valid,
  output logic [1:0] mux_sel,
  output logic       flush,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       health_fail,
  output logic [1:0] state
);

  localparam int MAXC =
    (SETTLE_BITS > RCT_CUTOFF) ? SETTLE_BITS : RCT_CUTOFF;
  localparam int CNT_W = $clog2(MAXC + 1);

  trng_state_e      st;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] settle_nxt;
  logic             sel_bit;
  logic             sel_valid;
  logic             trip;
  logic             switch_req;

  assign sel_bit    = raw_bits[mux_sel];
  assign sel_valid  = raw_valid[mux_sel];
  assign switch_req = (src_sel != mux_sel);
  assign settle_nxt = (settle_cnt != '1) ?
                      settle_cnt + 1'b1 : settle_cnt;
  assign state      = st;

  // Tests only see bits in RUN; leaving RUN clears them.
  trng_health_test #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF),
    .RUN_W      (CNT_W)
  ) u_health (
    .clk      (clk),
    .rst      (rst),
    .data_bit (sel_bit),
    .valid    (sel_valid),
    .clear    (st != ST_RUN),
    .enable   (bist_en),
    .trip     (trip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_IDLE;
      mux_sel     <= SRC_0;
      flush       <= 1'b0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      health_fail <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      flush     <= 1'b0;
      bit_valid <= 1'b0;
      if (!en) begin
        st          <= ST_IDLE;
        health_fail <= 1'b0;
        settle_cnt  <= '0;
      end else if (st == ST_IDLE || switch_req) begin
        st          <= ST_SETTLE;
        mux_sel     <= src_sel;
        flush       <= 1'b1;
        health_fail <= 1'b0;
        settle_cnt  <= '0;
      end else if (trip) begin
        st          <= ST_FAULT;
        health_fail <= 1'b1;
      end else begin
        case (st)
          ST_SETTLE: begin
            if (sel_valid) begin
              settle_cnt <= settle_nxt;
              if (settle_nxt == CNT_W'(SETTLE_BITS))
                st <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (sel_valid && req) begin
              bit_out   <= sel_bit;
              bit_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trng_source_ctrl.sv
// Directed bench for trng_source_ctrl: vector table plus
// hand sequences for switch, health-trip and reset corners.
module tb_trng_source_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] src_sel = 2'd0;
  logic       bist_en = 1'b0;
  logic       req = 1'b1;
  logic [3:0] raw_bits = 4'd0;
  logic [3:0] raw_valid = 4'd0;
  logic [1:0] mux_sel;
  logic       flush;
  logic       bit_out;
  logic       bit_valid;
  logic       health_fail;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  trng_source_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .src_sel     (src_sel),
    .bist_en     (bist_en),
    .req         (req),
    .raw_bits    (raw_bits),
    .raw_valid   (raw_valid),
    .mux_sel     (mux_sel),
    .flush       (flush),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .health_fail (health_fail),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic       bist;
    logic       req;
    logic [3:0] bits;
    logic [3:0] valid;
    int         reps;
    logic [1:0] e_st;
    logic [1:0] e_mux;
    logic       e_fl;
    logic       e_bv;
    logic       e_bo;
    logic       e_hf;
  } vec_t;

  vec_t tbl[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, state, 0);
    chk({tag, ".mux"}, mux_sel, 0);
    chk({tag, ".flush"}, flush, 0);
    chk({tag, ".bv"}, bit_valid, 0);
    chk({tag, ".bo"}, bit_out, 0);
    chk({tag, ".hf"}, health_fail, 0);
  endtask

  // Feed the settle bits on source s; none may be forwarded.
  task automatic settle(input int s);
    raw_valid = 4'b0001 << s;
    raw_bits  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("settle.bv", bit_valid, 0);
      chk("settle.fl", flush, 0);
      chk("settle.st", state, (i < 15) ? 1 : 2);
    end
  endtask

  // 64-bit window: 50 ones, longest run 7.
  function automatic logic pat50(input int i);
    if (i < 56) return (i % 8 == 0) ? 1'b0 : 1'b1;
    return (i == 63) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'h0, 1,
               2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h4, 4'h4, 1,
               2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h4, 4'h4, 15,
               2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h4, 4'h4, 1,
               2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h4, 4'h4, 1,
               2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h0, 4'h4, 1,
               2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'h4, 4'h0, 1,
               2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 4'hf, 4'h2, 1,
               2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h4, 4'h4, 1,
               2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int v = 0; v < 9; v++) begin
      rst = tbl[v].rst; en = tbl[v].en; src_sel = tbl[v].sel;
      bist_en = tbl[v].bist; req = tbl[v].req;
      raw_bits = tbl[v].bits; raw_valid = tbl[v].valid;
      for (int r = 0; r < tbl[v].reps; r++) begin
        tick();
        chk($sformatf("v%0d.state", v), state, tbl[v].e_st);
        chk($sformatf("v%0d.mux", v), mux_sel, tbl[v].e_mux);
        chk($sformatf("v%0d.flush", v), flush, tbl[v].e_fl);
        chk($sformatf("v%0d.bv", v), bit_valid, tbl[v].e_bv);
        chk($sformatf("v%0d.hf", v), health_fail, tbl[v].e_hf);
        if (tbl[v].e_bv)
          chk($sformatf("v%0d.bo", v), bit_out, tbl[v].e_bo);
      end
    end

    // Switch 2 -> 0, run, then 0 -> 3.
    req = 1'b1;
    src_sel = 2'd0; raw_valid = 4'h1;
    tick();
    chk("sw0.st", state, 1); chk("sw0.mux", mux_sel, 0);
    chk("sw0.fl", flush, 1);
    settle(0);
    raw_bits = 4'h1; raw_valid = 4'h1;
    tick();
    chk("run0.bv", bit_valid, 1); chk("run0.bo", bit_out, 1);
    src_sel = 2'd3; raw_valid = 4'h8;
    tick();
    chk("sw3.st", state, 1); chk("sw3.mux", mux_sel, 3);
    chk("sw3.fl", flush, 1); chk("sw3.bv", bit_valid, 0);
    settle(3);
    raw_bits = 4'h8; raw_valid = 4'h8;
    tick();
    chk("run3.bv", bit_valid, 1); chk("run3.bo", bit_out, 1);

    // Stuck-at-1 with BIST: RCT trips on 8th identical bit.
    bist_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("rct.st", state, (i < 8) ? 2 : 3);
      chk("rct.bv", bit_valid, (i < 8) ? 1 : 0);
      chk("rct.hf", health_fail, (i < 8) ? 0 : 1);
    end
    tick();
    chk("fault.st", state, 3); chk("fault.bv", bit_valid, 0);
    chk("fault.hf", health_fail, 1);
    src_sel = 2'd1; raw_valid = 4'h2;
    tick();
    chk("rec.st", state, 1); chk("rec.hf", health_fail, 0);
    chk("rec.fl", flush, 1); chk("rec.mux", mux_sel, 1);

    // APT: balanced window passes, 50-ones window trips.
    settle(1);
    for (int i = 0; i < 64; i++) begin
      raw_bits = {2'b00, logic'(i % 2), 1'b0};
      tick();
    end
    chk("apt32.st", state, 2); chk("apt32.hf", health_fail, 0);
    for (int i = 0; i < 64; i++) begin
      raw_bits = {2'b00, pat50(i), 1'b0};
      tick();
      if (i == 62) chk("apt50.pre", state, 2);
    end
    chk("apt50.st", state, 3); chk("apt50.hf", health_fail, 1);
    chk("apt50.bv", bit_valid, 0);

    // Same windows with BIST off: no trip.
    bist_en = 1'b0; src_sel = 2'd2; raw_valid = 4'h4;
    tick();
    chk("nb.st", state, 1); chk("nb.hf", health_fail, 0);
    settle(2);
    for (int i = 0; i < 128; i++) begin
      raw_bits = {1'b0, (i < 64) ? logic'(i % 2) : pat50(i - 64),
                  2'b00};
      tick();
    end
    chk("nb.end.st", state, 2); chk("nb.end.hf", health_fail, 0);

    // Switch coincides with RCT trip: switch wins.
    bist_en = 1'b1; raw_bits = 4'h4; raw_valid = 4'h4;
    for (int i = 0; i < 7; i++) tick();
    chk("pre.st", state, 2);
    src_sel = 2'd0;
    tick();
    chk("swtrip.st", state, 1); chk("swtrip.hf", health_fail, 0);
    chk("swtrip.mux", mux_sel, 0); chk("swtrip.fl", flush, 1);

    // req=0 in RUN: consumed, not forwarded.
    settle(0);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      raw_bits = {3'b000, logic'(i % 2)};
      tick();
      chk("noreq.bv", bit_valid, 0); chk("noreq.st", state, 2);
    end

    // Reset mid-SETTLE and mid-RUN; en=0 in RUN.
    req = 1'b1; src_sel = 2'd1; raw_valid = 4'h2;
    tick();
    chk("ms.st", state, 1);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    chk_reset("rst_settle");
    rst = 1'b0;
    tick();
    chk("re.st", state, 1); chk("re.fl", flush, 1);
    settle(1);
    raw_bits = 4'h2;
    tick(); tick();
    chk("mr.bv", bit_valid, 1); chk("mr.bo", bit_out, 1);
    rst = 1'b1;
    tick();
    chk_reset("rst_run");
    rst = 1'b0;
    tick();
    settle(1);
    tick();
    chk("pre_off.bv", bit_valid, 1);
    en = 1'b0;
    tick();
    chk("off.st", state, 0); chk("off.fl", flush, 0);
    chk("off.bv", bit_valid, 0);
    tick();
    chk("off2.st", state, 0); chk("off2.fl", flush, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
